yarp_lsu: RTL and testbench

YARP_LSU -- requirements
Module: yarp_lsu

---
 rtl/yarp_pkg.sv | 39 +++
 rtl/yarp_lsu_extend.sv | 33 +++
 rtl/yarp_lsu.sv | 166 ++++++++++++++++
 tb/tb_yarp_lsu.sv | 376 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/yarp_pkg.sv
// Shared YARP definitions: memory access sizes, LSU FSM states and byte-enable helpers.
package yarp_pkg;

  typedef enum logic [1:0] {
    BYTE        = 2'b00,
    HALF_WORD   = 2'b01,
    DOUBLE_WORD = 2'b10,
    WORD        = 2'b11
  } mem_access_size_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    WAIT = 2'b10,
    RESP = 2'b11
  } lsu_state_t;

  // Low offset bits that must be zero for a naturally aligned access of this size.
  function automatic logic [2:0] size_align_mask(mem_access_size_t size);
    case (size)
      BYTE:        return 3'b000;
      HALF_WORD:   return 3'b001;
      WORD:        return 3'b011;
      default:     return 3'b111;
    endcase
  endfunction

  function automatic logic [7:0] size_to_be(mem_access_size_t size, logic [2:0] offset);
    logic [7:0] base;
    case (size)
      BYTE:        base = 8'h01;
      HALF_WORD:   base = 8'h03;
      WORD:        base = 8'h0F;
      default:     base = 8'hFF;
    endcase
    return base << offset;
  endfunction

endpackage

// File: rtl/yarp_lsu_extend.sv
// Load lane selection and sign/zero extension of a memory read word.
module yarp_lsu_extend
  import yarp_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0]            rdata_i,
  input  logic [$clog2(XLEN/8)-1:0]  off_i,
  input  mem_access_size_t           size_i,
  input  logic                       zext_i,
  output logic [XLEN-1:0]            data_o
);

  logic [XLEN-1:0]        lane;
  logic [XLEN-1:0]        left;
  logic signed [XLEN-1:0] sgn;
  logic [6:0]             shamt;

  // Move the field to the top, then shift back down arithmetically or logically.
  always_comb begin
    lane = rdata_i >> {off_i, 3'b000};
    case (size_i)
      BYTE:      shamt = 7'(XLEN - 8);
      HALF_WORD: shamt = 7'(XLEN - 16);
      WORD:      shamt = 7'(XLEN - 32);
      default:   shamt = 7'd0;
    endcase
    left   = lane << shamt;
    sgn    = $signed(left) >>> shamt;
    data_o = zext_i ? (left >> shamt) : sgn;
  end

endmodule

// File: rtl/yarp_lsu.sv
// YARP load/store unit: single outstanding access with grant/rvalid handshake and WAIT timeout.
// Build option YARP_LSU_MISALIGN_CHECK_EN: misaligned accesses fail without a memory request.
module yarp_lsu
  import yarp_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                lsu_req_i,
  input  logic                lsu_we_i,
  input  logic [ADDR_W-1:0]   lsu_addr_i,
  input  logic [XLEN-1:0]     lsu_wdata_i,
  input  mem_access_size_t    lsu_size_i,
  input  logic                lsu_zero_ext_i,
  output logic                lsu_ready_o,
  output logic                lsu_rvalid_o,
  output logic [XLEN-1:0]     lsu_rdata_o,
  output logic                lsu_err_o,
  output logic                mem_req_o,
  output logic                mem_we_o,
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic [XLEN/8-1:0]   mem_be_o,
  output logic [XLEN-1:0]     mem_wdata_o,
  input  logic                mem_gnt_i,
  input  logic                mem_rvalid_i,
  input  logic [XLEN-1:0]     mem_rdata_i
);

  localparam int BE_W  = XLEN / 8;
  localparam int OFF_W = $clog2(BE_W);
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  lsu_state_t        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [BE_W-1:0]   be_q, be_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;
  logic [XLEN-1:0]   rdata_q, rdata_d;
  logic              we_q, we_d;
  logic              zext_q, zext_d;
  logic              err_q, err_d;
  mem_access_size_t  size_q, size_d;
  logic [OFF_W-1:0]  off_q, off_d;

  logic [OFF_W-1:0]  req_off;
  logic              misaligned;
  logic              bad_req;
  logic [XLEN-1:0]   ext_data;

`ifdef YARP_LSU_MISALIGN_CHECK_EN
  assign misaligned = |(lsu_addr_i[OFF_W-1:0] & OFF_W'(size_align_mask(lsu_size_i)));
`else
  assign misaligned = 1'b0;
`endif

  // Without the check, the offset is forced to natural alignment for the access size.
  assign req_off = lsu_addr_i[OFF_W-1:0] & ~OFF_W'(size_align_mask(lsu_size_i));
  assign bad_req = misaligned || ((XLEN == 32) && (lsu_size_i == DOUBLE_WORD));

  yarp_lsu_extend #(.XLEN(XLEN)) u_extend (
    .rdata_i (mem_rdata_i),
    .off_i   (off_q),
    .size_i  (size_q),
    .zext_i  (zext_q),
    .data_o  (ext_data)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    we_d    = we_q;
    zext_d  = zext_q;
    err_d   = err_q;
    size_d  = size_q;
    off_d   = off_q;
    case (state_q)
      IDLE: begin
        if (lsu_req_i) begin
          addr_d  = {lsu_addr_i[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
          be_d    = BE_W'(size_to_be(lsu_size_i, 3'(req_off)));
          wdata_d = lsu_wdata_i << {req_off, 3'b000};
          we_d    = lsu_we_i;
          zext_d  = lsu_zero_ext_i;
          size_d  = lsu_size_i;
          off_d   = req_off;
          rdata_d = '0;
          err_d   = bad_req;
          state_d = bad_req ? RESP : REQ;
        end
      end
      REQ: begin
        if (mem_gnt_i) begin
          cnt_d   = '0;
          state_d = WAIT;
        end
      end
      WAIT: begin
        // Data arriving in the final counted cycle still beats the timeout.
        if (mem_rvalid_i) begin
          rdata_d = we_q ? '0 : ext_data;
          err_d   = 1'b0;
          state_d = RESP;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RESP: begin
        rdata_d = '0;
        err_d   = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      we_q    <= 1'b0;
      zext_q  <= 1'b0;
      err_q   <= 1'b0;
      size_q  <= BYTE;
      off_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      we_q    <= we_d;
      zext_q  <= zext_d;
      err_q   <= err_d;
      size_q  <= size_d;
      off_q   <= off_d;
    end
  end

  // Ready is masked by reset so the unit never advertises acceptance while held in reset.
  assign lsu_ready_o  = reset_n && (state_q == IDLE);
  assign lsu_rvalid_o = (state_q == RESP);
  assign lsu_rdata_o  = rdata_q;
  assign lsu_err_o    = err_q;
  assign mem_req_o    = (state_q == REQ);
  assign mem_we_o     = we_q;
  assign mem_addr_o   = addr_q;
  assign mem_be_o     = be_q;
  assign mem_wdata_o  = wdata_q;

endmodule

// File: tb/tb_yarp_lsu.sv
// Directed bench for yarp_lsu (XLEN=32, TIMEOUT=4).
module tb_yarp_lsu;
  import yarp_pkg::*;

  localparam int XLEN    = 32;
  localparam int ADDR_W  = 32;
  localparam int TIMEOUT = 4;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              lsu_req_i = 1'b0;
  logic              lsu_we_i = 1'b0;
  logic [ADDR_W-1:0] lsu_addr_i = '0;
  logic [XLEN-1:0]   lsu_wdata_i = '0;
  mem_access_size_t  lsu_size_i = BYTE;
  logic              lsu_zero_ext_i = 1'b0;
  logic              lsu_ready_o, lsu_rvalid_o, lsu_err_o;
  logic [XLEN-1:0]   lsu_rdata_o;
  logic              mem_req_o, mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [XLEN/8-1:0] mem_be_o;
  logic [XLEN-1:0]   mem_wdata_o;
  logic              mem_gnt_i = 1'b0;
  logic              mem_rvalid_i = 1'b0;
  logic [XLEN-1:0]   mem_rdata_i = '0;

  int n_cmp = 0;
  int n_bad = 0;

  yarp_lsu #(.XLEN(XLEN), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .lsu_req_i      (lsu_req_i),
    .lsu_we_i       (lsu_we_i),
    .lsu_addr_i     (lsu_addr_i),
    .lsu_wdata_i    (lsu_wdata_i),
    .lsu_size_i     (lsu_size_i),
    .lsu_zero_ext_i (lsu_zero_ext_i),
    .lsu_ready_o    (lsu_ready_o),
    .lsu_rvalid_o   (lsu_rvalid_o),
    .lsu_rdata_o    (lsu_rdata_o),
    .lsu_err_o      (lsu_err_o),
    .mem_req_o      (mem_req_o),
    .mem_we_o       (mem_we_o),
    .mem_addr_o     (mem_addr_o),
    .mem_be_o       (mem_be_o),
    .mem_wdata_o    (mem_wdata_o),
    .mem_gnt_i      (mem_gnt_i),
    .mem_rvalid_i   (mem_rvalid_i),
    .mem_rdata_i    (mem_rdata_i)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Present a request for one cycle; returns at the negedge after acceptance.
  task automatic issue(input logic we, input logic [31:0] addr, input mem_access_size_t size,
                       input logic zext, input logic [31:0] wdata);
    lsu_req_i      = 1'b1;
    lsu_we_i       = we;
    lsu_addr_i     = addr;
    lsu_size_i     = size;
    lsu_zero_ext_i = zext;
    lsu_wdata_i    = wdata;
    @(negedge clk);
    lsu_req_i = 1'b0;
  endtask

  // From REQ: grant after gnt_wait cycles, then return read data; ends in RESP.
  task automatic run_mem(input int gnt_wait, input logic [31:0] rd);
    repeat (gnt_wait) @(negedge clk);
    mem_gnt_i = 1'b1;
    @(negedge clk);
    mem_gnt_i    = 1'b0;
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = rd;
    @(negedge clk);
    mem_rvalid_i = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if ({lsu_ready_o, lsu_rvalid_o, lsu_err_o, mem_req_o, mem_we_o} !== 5'b0) begin
      n_bad++;
      $display("FAIL reset_ctrl: got %b expected 00000",
               {lsu_ready_o, lsu_rvalid_o, lsu_err_o, mem_req_o, mem_we_o});
    end
    n_cmp++;
    if ({lsu_rdata_o, mem_be_o, mem_addr_o, mem_wdata_o} !== '0) begin
      n_bad++;
      $display("FAIL reset_data: rdata %h be %h addr %h wdata %h expected all zero",
               lsu_rdata_o, mem_be_o, mem_addr_o, mem_wdata_o);
    end
    reset_n = 1'b1;
    #1;
    n_cmp++;
    if (lsu_ready_o !== 1'b1) begin
      n_bad++;
      $display("FAIL ready_after_release: got %b expected 1", lsu_ready_o);
    end
    @(negedge clk);
  endtask

  task automatic test_load_byte();
    issue(1'b0, 32'h0000_1003, BYTE, 1'b0, 32'h0);
    n_cmp++;
    if ({mem_req_o, mem_we_o, lsu_ready_o} !== 3'b100 || mem_addr_o !== 32'h1000
        || mem_be_o !== 4'b1000) begin
      n_bad++;
      $display("FAIL lb_req: req/we/rdy %b addr %h be %b expected 100 00001000 1000",
               {mem_req_o, mem_we_o, lsu_ready_o}, mem_addr_o, mem_be_o);
    end
    mem_gnt_i = 1'b1;
    @(negedge clk);
    mem_gnt_i = 1'b0;
    n_cmp++;
    if ({mem_req_o, lsu_rvalid_o} !== 2'b00) begin
      n_bad++;
      $display("FAIL lb_wait: req/rvalid %b expected 00", {mem_req_o, lsu_rvalid_o});
    end
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = 32'h80FF_FFFF;
    @(negedge clk);
    mem_rvalid_i = 1'b0;
    n_cmp++;
    if (lsu_rvalid_o !== 1'b1 || lsu_rdata_o !== 32'hFFFF_FF80 || lsu_err_o !== 1'b0) begin
      n_bad++;
      $display("FAIL lb_resp: rvalid %b rdata %h err %b expected 1 ffffff80 0",
               lsu_rvalid_o, lsu_rdata_o, lsu_err_o);
    end
    @(negedge clk);
    n_cmp++;
    if ({lsu_rvalid_o, lsu_ready_o} !== 2'b01) begin
      n_bad++;
      $display("FAIL lb_idle: rvalid/ready %b expected 01", {lsu_rvalid_o, lsu_ready_o});
    end
  endtask

  task automatic test_store_half();
    issue(1'b1, 32'h0000_2002, HALF_WORD, 1'b0, 32'h0000_ABCD);
    n_cmp++;
    if (mem_addr_o !== 32'h2000 || mem_be_o !== 4'b1100 || mem_wdata_o[31:16] !== 16'hABCD
        || mem_we_o !== 1'b1) begin
      n_bad++;
      $display("FAIL sh_req: addr %h be %b wdata %h we %b expected 00002000 1100 abcd---- 1",
               mem_addr_o, mem_be_o, mem_wdata_o, mem_we_o);
    end
    run_mem(0, 32'hDEAD_BEEF);
    n_cmp++;
    if (lsu_rvalid_o !== 1'b1 || lsu_rdata_o !== 32'h0 || lsu_err_o !== 1'b0) begin
      n_bad++;
      $display("FAIL sh_resp: rvalid %b rdata %h err %b expected 1 00000000 0",
               lsu_rvalid_o, lsu_rdata_o, lsu_err_o);
    end
    @(negedge clk);
  endtask

  task automatic test_gnt_stall();
    issue(1'b0, 32'h0000_3000, WORD, 1'b0, 32'h0);
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h3000 || lsu_ready_o !== 1'b0
          || mem_be_o !== 4'hF) begin
        n_bad++;
        $display("FAIL stall_%0d: req %b addr %h ready %b be %h expected 1 00003000 0 f",
                 i, mem_req_o, mem_addr_o, lsu_ready_o, mem_be_o);
      end
      @(negedge clk);
    end
    run_mem(0, 32'h1234_5678);
    n_cmp++;
    if (lsu_rvalid_o !== 1'b1 || lsu_rdata_o !== 32'h1234_5678) begin
      n_bad++;
      $display("FAIL stall_resp: rvalid %b rdata %h expected 1 12345678", lsu_rvalid_o, lsu_rdata_o);
    end
    @(negedge clk);
  endtask

  task automatic test_extend();
    issue(1'b0, 32'h0000_6002, HALF_WORD, 1'b1, 32'h0);
    run_mem(0, 32'h8001_5555);
    n_cmp++;
    if (lsu_rdata_o !== 32'h0000_8001) begin
      n_bad++;
      $display("FAIL zext_half: got %h expected 00008001", lsu_rdata_o);
    end
    @(negedge clk);
    issue(1'b0, 32'h0000_6000, HALF_WORD, 1'b0, 32'h0);
    run_mem(0, 32'h1234_F00D);
    n_cmp++;
    if (lsu_rdata_o !== 32'hFFFF_F00D) begin
      n_bad++;
      $display("FAIL sext_half: got %h expected fffff00d", lsu_rdata_o);
    end
    @(negedge clk);
    issue(1'b0, 32'h0000_6001, BYTE, 1'b0, 32'h0);
    run_mem(0, 32'h0000_7F00);
    n_cmp++;
    if (lsu_rdata_o !== 32'h0000_007F) begin
      n_bad++;
      $display("FAIL sext_byte_pos: got %h expected 0000007f", lsu_rdata_o);
    end
    @(negedge clk);
  endtask

  task automatic test_timeout();
    int seen;
    issue(1'b0, 32'h0000_4000, WORD, 1'b0, 32'h0);
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = 32'hBAD0_BAD0;
    @(negedge clk);
    mem_rvalid_i = 1'b0;
    n_cmp++;
    if ({mem_req_o, lsu_rvalid_o} !== 2'b10) begin
      n_bad++;
      $display("FAIL rvalid_outside_wait: req/rvalid %b expected 10", {mem_req_o, lsu_rvalid_o});
    end
    mem_gnt_i = 1'b1;
    @(negedge clk);
    mem_gnt_i = 1'b0;
    seen = 0;
    for (int i = 0; i < TIMEOUT; i++) begin
      if (lsu_rvalid_o) seen++;
      @(negedge clk);
    end
    n_cmp++;
    if (seen !== 0) begin
      n_bad++;
      $display("FAIL to_early: got %0d early responses expected 0", seen);
    end
    n_cmp++;
    if (lsu_rvalid_o !== 1'b1 || lsu_err_o !== 1'b1 || lsu_rdata_o !== 32'h0) begin
      n_bad++;
      $display("FAIL to_resp: rvalid %b err %b rdata %h expected 1 1 00000000",
               lsu_rvalid_o, lsu_err_o, lsu_rdata_o);
    end
    @(negedge clk);
    n_cmp++;
    if ({lsu_rvalid_o, lsu_err_o, lsu_ready_o} !== 3'b001) begin
      n_bad++;
      $display("FAIL to_once: rvalid/err/ready %b expected 001", {lsu_rvalid_o, lsu_err_o, lsu_ready_o});
    end
    issue(1'b0, 32'h0000_4004, WORD, 1'b0, 32'h0);
    mem_gnt_i = 1'b1;
    @(negedge clk);
    mem_gnt_i = 1'b0;
    repeat (TIMEOUT - 1) @(negedge clk);
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = 32'hCAFE_F00D;
    @(negedge clk);
    mem_rvalid_i = 1'b0;
    n_cmp++;
    if (lsu_rvalid_o !== 1'b1 || lsu_err_o !== 1'b0 || lsu_rdata_o !== 32'hCAFE_F00D) begin
      n_bad++;
      $display("FAIL late_data: rvalid %b err %b rdata %h expected 1 0 cafef00d",
               lsu_rvalid_o, lsu_err_o, lsu_rdata_o);
    end
    @(negedge clk);
  endtask

  task automatic test_misalign();
    issue(1'b0, 32'h0000_1001, WORD, 1'b0, 32'h0);
`ifdef YARP_LSU_MISALIGN_CHECK_EN
    n_cmp++;
    if ({mem_req_o, lsu_rvalid_o, lsu_err_o} !== 3'b011) begin
      n_bad++;
      $display("FAIL misalign_err: req/rvalid/err %b expected 011", {mem_req_o, lsu_rvalid_o, lsu_err_o});
    end
    @(negedge clk);
`else
    n_cmp++;
    if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h1000 || mem_be_o !== 4'hF) begin
      n_bad++;
      $display("FAIL misalign_word: req %b addr %h be %h expected 1 00001000 f",
               mem_req_o, mem_addr_o, mem_be_o);
    end
    run_mem(0, 32'h1122_3344);
    n_cmp++;
    if (lsu_rdata_o !== 32'h1122_3344 || lsu_err_o !== 1'b0) begin
      n_bad++;
      $display("FAIL misalign_word_data: rdata %h err %b expected 11223344 0", lsu_rdata_o, lsu_err_o);
    end
    @(negedge clk);
    issue(1'b0, 32'h0000_2003, HALF_WORD, 1'b0, 32'h0);
    n_cmp++;
    if (mem_be_o !== 4'b1100) begin
      n_bad++;
      $display("FAIL misalign_half_be: got %b expected 1100", mem_be_o);
    end
    run_mem(0, 32'hA5A5_5A5A);
    n_cmp++;
    if (lsu_rdata_o !== 32'hFFFF_A5A5) begin
      n_bad++;
      $display("FAIL misalign_half_data: got %h expected ffffa5a5", lsu_rdata_o);
    end
    @(negedge clk);
`endif
  endtask

  task automatic test_dword();
    issue(1'b0, 32'h0000_5000, DOUBLE_WORD, 1'b0, 32'h0);
    n_cmp++;
    if ({mem_req_o, lsu_rvalid_o, lsu_err_o} !== 3'b011) begin
      n_bad++;
      $display("FAIL dword_err: req/rvalid/err %b expected 011", {mem_req_o, lsu_rvalid_o, lsu_err_o});
    end
    @(negedge clk);
    n_cmp++;
    if ({lsu_ready_o, lsu_rvalid_o, mem_req_o} !== 3'b100) begin
      n_bad++;
      $display("FAIL dword_idle: ready/rvalid/req %b expected 100", {lsu_ready_o, lsu_rvalid_o, mem_req_o});
    end
  endtask

  task automatic test_reset_mid();
    int seen;
    issue(1'b1, 32'h0000_7004, WORD, 1'b0, 32'h5555_AAAA);
    mem_gnt_i = 1'b1;
    @(negedge clk);
    mem_gnt_i    = 1'b0;
    reset_n      = 1'b0;
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = 32'hFFFF_0000;
    #1;
    n_cmp++;
    if ({lsu_ready_o, lsu_rvalid_o, lsu_err_o, mem_req_o, mem_we_o} !== 5'b0
        || {lsu_rdata_o, mem_be_o, mem_addr_o, mem_wdata_o} !== '0) begin
      n_bad++;
      $display("FAIL mid_reset_outs: ctrl %b rdata %h be %h addr %h wdata %h expected all zero",
               {lsu_ready_o, lsu_rvalid_o, lsu_err_o, mem_req_o, mem_we_o},
               lsu_rdata_o, mem_be_o, mem_addr_o, mem_wdata_o);
    end
    @(negedge clk);
    mem_rvalid_i = 1'b0;
    reset_n      = 1'b1;
    #1;
    n_cmp++;
    if (lsu_ready_o !== 1'b1) begin
      n_bad++;
      $display("FAIL mid_reset_ready: got %b expected 1", lsu_ready_o);
    end
    seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (lsu_rvalid_o || mem_req_o) seen++;
    end
    n_cmp++;
    if (seen !== 0) begin
      n_bad++;
      $display("FAIL mid_reset_dropped: got %0d stray cycles expected 0", seen);
    end
  endtask

  initial begin
    test_reset();
    test_load_byte();
    test_store_half();
    test_gnt_stall();
    test_extend();
    test_timeout();
    test_misalign();
    test_dword();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
